// File: rtl/fetch_unit.sv
// Instruction fetch/decode stage feeding the nRisc controller: owns the PC,
// reads a synchronous instruction memory and presents one decoded instruction per issue window.
module fetch_unit #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clock,
   input  logic            reset_n,
   output logic [PC_W-1:0] imem_addr,
   input  logic [8:0]      imem_rdata,
   input  logic            stall,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   output logic [2:0]      instruction,
   output logic [2:0]      reg_alpha,
   output logic [2:0]      reg_beta,
   output logic [7:0]      data,
   output logic            issue_valid
);

   localparam logic [2:0]      OP_LI  = 3'b011;
   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      IMM_WAIT,
      IMM_CAP,
      ISSUE
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [PC_W-1:0] pc;

   assign imem_addr = pc;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= FETCH;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         FETCH:    next_state = DECODE;
         DECODE:   next_state = (imem_rdata[8:6] == OP_LI) ? IMM_WAIT : ISSUE;
         IMM_WAIT: next_state = IMM_CAP;
         IMM_CAP:  next_state = ISSUE;
         ISSUE:    next_state = stall ? ISSUE : FETCH;
         default:  next_state = FETCH;
      endcase
   end

   always_comb begin
      issue_valid = (state == ISSUE);
   end

   // The LI immediate lives in the word after the opcode, so the PC is advanced
   // in DECODE to point the memory at it; the ISSUE increment then skips past it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc          <= RESET_PC;
         instruction <= '0;
         reg_alpha   <= '0;
         reg_beta    <= '0;
         data        <= '0;
      end else begin
         case (state)
            DECODE: begin
               instruction <= imem_rdata[8:6];
               reg_alpha   <= imem_rdata[5:3];
               reg_beta    <= imem_rdata[2:0];
               if (imem_rdata[8:6] == OP_LI) begin
                  pc <= pc + PC_ONE;
               end else begin
                  data <= '0;
               end
            end
            IMM_CAP: begin
               data <= imem_rdata[7:0];
            end
            ISSUE: begin
               if (!stall) begin
                  pc <= jump ? jump_target : pc + PC_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a directed program is pushed as expected issues,
// and a monitor compares every issue window plus the PC fetched right after it.
module tb_fetch_unit;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [7:0] imem_addr;
   logic [8:0] imem_rdata;
   logic       stall;
   logic       jump;
   logic [7:0] jump_target;
   logic [2:0] instruction;
   logic [2:0] reg_alpha;
   logic [2:0] reg_beta;
   logic [7:0] data;
   logic       issue_valid;

   logic [8:0] mem [256];

   typedef struct {
      logic [2:0] instr;
      logic [2:0] alpha;
      logic [2:0] beta;
      logic [7:0] data;
      logic [7:0] next_addr;
      int         stall_cycles;
      logic       jmp;
      logic [7:0] target;
   } slot_t;

   slot_t slots [14];
   slot_t exp_q [$];
   slot_t cur;

   int compared   = 0;
   int mismatched = 0;
   bit prev_valid = 1'b0;
   bit have_pending = 1'b0;
   bit run_ok;

   fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .jump        (jump),
      .jump_target (jump_target),
      .instruction (instruction),
      .reg_alpha   (reg_alpha),
      .reg_beta    (reg_beta),
      .data        (data),
      .issue_valid (issue_valid)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      imem_rdata <= mem[imem_addr];
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic wait_valid(input logic level, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (issue_valid === level) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL timeout: issue_valid never reached %0b, got %0b", level, issue_valid);
      end
   endtask

   // Monitor: pops one expectation per rising issue window, then checks the
   // address fetched once the window closes.
   always @(negedge clock) begin
      if (!reset_n) begin
         prev_valid   = 1'b0;
         have_pending = 1'b0;
      end else begin
         if (issue_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected_issue: got instr %0d, expected no issue", instruction);
            end else begin
               cur = exp_q.pop_front();
               check_output("instruction", 32'(instruction), 32'(cur.instr));
               check_output("reg_alpha", 32'(reg_alpha), 32'(cur.alpha));
               check_output("reg_beta", 32'(reg_beta), 32'(cur.beta));
               check_output("data", 32'(data), 32'(cur.data));
               have_pending = 1'b1;
            end
         end else if (!issue_valid && prev_valid && have_pending) begin
            check_output("next_imem_addr", 32'(imem_addr), 32'(cur.next_addr));
            have_pending = 1'b0;
         end
         prev_valid = issue_valid;
      end
   end

   // Drives stall/jump for each issue window in the given slot range; a stalled
   // window is also checked for frozen outputs and PC.
   task automatic apply_stimulus(input int first, input int last, input logic [7:0] hold_addr, output bit ok);
      ok = 1'b1;
      for (int s = first; s <= last; s++) begin
         exp_q.push_back(slots[s]);
         wait_valid(1'b1, ok);
         if (!ok) return;
         jump        = slots[s].jmp;
         jump_target = slots[s].target;
         if (slots[s].stall_cycles > 0) begin
            stall = 1'b1;
            repeat (slots[s].stall_cycles) begin
               @(negedge clock);
               check_output("stall_issue_valid", 32'(issue_valid), 32'd1);
               check_output("stall_instruction", 32'(instruction), 32'(slots[s].instr));
               check_output("stall_alpha", 32'(reg_alpha), 32'(slots[s].alpha));
               check_output("stall_imem_addr", 32'(imem_addr), 32'(hold_addr));
            end
            stall = 1'b0;
         end
         wait_valid(1'b0, ok);
         jump = 1'b0;
         if (!ok) return;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 9'h000;
      mem[8'h00] = 9'b000_001_010;
      mem[8'h01] = 9'b001_011_100;
      mem[8'h02] = 9'b010_110_111;
      mem[8'h03] = 9'b100_000_001;
      mem[8'h04] = 9'b011_101_000;
      mem[8'h05] = 9'h0A5;
      mem[8'h06] = 9'b011_010_001;
      mem[8'h07] = 9'h1C3;
      mem[8'h08] = 9'b111_100_011;
      mem[8'h20] = 9'b110_010_101;
      mem[8'h40] = 9'b101_111_110;
      mem[8'hFE] = 9'b110_001_001;
      mem[8'hFF] = 9'b010_011_011;

      slots[0]  = '{3'd0, 3'd1, 3'd2, 8'h00, 8'h01, 0, 1'b0, 8'h00};
      slots[1]  = '{3'd1, 3'd3, 3'd4, 8'h00, 8'h02, 0, 1'b0, 8'h00};
      slots[2]  = '{3'd2, 3'd6, 3'd7, 8'h00, 8'h03, 0, 1'b0, 8'h00};
      slots[3]  = '{3'd4, 3'd0, 3'd1, 8'h00, 8'h04, 0, 1'b0, 8'h00};
      slots[4]  = '{3'd3, 3'd5, 3'd0, 8'hA5, 8'h06, 0, 1'b0, 8'h00};
      slots[5]  = '{3'd3, 3'd2, 3'd1, 8'hC3, 8'h08, 0, 1'b0, 8'h00};
      slots[6]  = '{3'd7, 3'd4, 3'd3, 8'h00, 8'h20, 0, 1'b1, 8'h20};
      slots[7]  = '{3'd6, 3'd2, 3'd5, 8'h00, 8'h40, 3, 1'b1, 8'h40};
      slots[8]  = '{3'd5, 3'd7, 3'd6, 8'h00, 8'hFE, 0, 1'b1, 8'hFE};
      slots[9]  = '{3'd6, 3'd1, 3'd1, 8'h00, 8'hFF, 0, 1'b0, 8'h00};
      slots[10] = '{3'd2, 3'd3, 3'd3, 8'h00, 8'h00, 0, 1'b0, 8'h00};
      slots[11] = '{3'd0, 3'd7, 3'd4, 8'h00, 8'hFF, 0, 1'b1, 8'hFF};
      slots[12] = '{3'd3, 3'd6, 3'd5, 8'h3C, 8'h01, 0, 1'b0, 8'h00};
      slots[13] = '{3'd1, 3'd3, 3'd4, 8'h00, 8'h02, 0, 1'b0, 8'h00};

      reset_n     = 1'b0;
      stall       = 1'b0;
      jump        = 1'b0;
      jump_target = 8'h00;
      repeat (2) @(negedge clock);
      check_output("reset_issue_valid", 32'(issue_valid), 32'd0);
      check_output("reset_instruction", 32'(instruction), 32'd0);
      check_output("reset_data", 32'(data), 32'd0);
      check_output("reset_imem_addr", 32'(imem_addr), 32'd0);
      reset_n = 1'b1;

      apply_stimulus(0, 10, 8'h20, run_ok);

      if (run_ok) begin
         // Second program: LI sitting at the last address wraps to word 0 for its immediate.
         @(posedge clock);
         #1;
         reset_n = 1'b0;
         mem[8'h00] = 9'h03C;
         mem[8'hFF] = 9'b011_110_101;
         mem[8'h02] = 9'b011_001_001;
         @(negedge clock);
         reset_n = 1'b1;
         apply_stimulus(11, 13, 8'h00, run_ok);
      end

      if (run_ok) begin
         repeat (2) @(posedge clock);
         #1;
         check_output("pre_reset_imem_addr", 32'(imem_addr), 32'h03);
         check_output("pre_reset_instruction", 32'(instruction), 32'd3);
         reset_n = 1'b0;
         #1;
         check_output("async_reset_issue_valid", 32'(issue_valid), 32'd0);
         check_output("async_reset_instruction", 32'(instruction), 32'd0);
         check_output("async_reset_alpha", 32'(reg_alpha), 32'd0);
         check_output("async_reset_beta", 32'(reg_beta), 32'd0);
         check_output("async_reset_data", 32'(data), 32'd0);
         check_output("async_reset_imem_addr", 32'(imem_addr), 32'd0);
         repeat (2) @(negedge clock);
      end

      check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
